// File: rtl/memory_arbiter_pkg.sv
// Shared CPU package: FSM encoding and default bus widths for the memory arbiter.
package memory_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // IDLE: accepting requests; D_ACC/I_ACC: waiting on backing memory;
  // DONE: presenting the one-cycle ready pulse to the granted port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single backing memory.
// Data wins contention unless it has already taken MAX_DBURST grants in a row
// while a fetch was waiting; then the fetch is served once.
//
// Handshake: a requester holds its request level-high; the arbiter answers
// with a one-cycle ready pulse. The backing memory sees mem_req_o held with
// stable address/data until it returns a one-cycle mem_ack_i (no timeout).
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_DBURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_data_o,
  output logic              i_ready_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o,
  output arb_state_t        state_o
);

  localparam int CNT_W = (MAX_DBURST < 1) ? 1 : $clog2(MAX_DBURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DBURST);

  arb_state_t       state, state_next;
  logic [CNT_W-1:0] dcnt;
  logic             d_pend;
  logic             burst_full;
  logic             grant_d;
  logic             grant_i;
  logic             in_access;

  assign d_pend     = d_read_i | d_write_i;
  assign burst_full = (dcnt == MAX_CNT);
  assign in_access  = (state == D_ACC) || (state == I_ACC);
  assign state_o    = state;

  assign stall_o = (i_req_i & ~i_ready_o) | (d_pend & ~d_ready_o);

  // Grant decision, only meaningful in IDLE.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      grant_d = d_pend & ~(i_req_i & burst_full);
      grant_i = i_req_i & ~grant_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (grant_d) state_next = D_ACC;
             else if (grant_i) state_next = I_ACC;
      D_ACC: if (mem_ack_i) state_next = DONE;
      I_ACC: if (mem_ack_i) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Consecutive data-grant counter, saturating at MAX_DBURST.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dcnt <= '0;
    end else if (grant_i) begin
      dcnt <= '0;
    end else if (grant_d) begin
      if (!i_req_i)        dcnt <= '0;
      else if (!burst_full) dcnt <= dcnt + CNT_W'(1);
    end
  end

  // Memory-side request, captured read data, ready pulses and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      i_data_o    <= '0;
      d_rdata_o   <= '0;
      i_ready_o   <= 1'b0;
      d_ready_o   <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      i_ready_o <= 1'b0;
      d_ready_o <= 1'b0;
      if (grant_d) begin
        mem_req_o   <= 1'b1;
        // A simultaneous read+write resolves to a write and is flagged.
        mem_we_o    <= d_write_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
        if (d_read_i && d_write_i) err_o <= 1'b1;
      end else if (grant_i) begin
        mem_req_o  <= 1'b1;
        mem_we_o   <= 1'b0;
        mem_addr_o <= i_addr_i;
      end
      if (in_access && mem_ack_i) begin
        mem_req_o <= 1'b0;
        mem_we_o  <= 1'b0;
        if (state == I_ACC) begin
          i_data_o  <= mem_rdata_i;
          i_ready_o <= 1'b1;
        end else begin
          if (!mem_we_o) d_rdata_o <= mem_rdata_i;
          d_ready_o <= 1'b1;
        end
      end
      // An ack with no access outstanding is a protocol error and is dropped.
      if (!in_access && mem_ack_i) err_o <= 1'b1;
    end
  end

endmodule
